// File: rtl/wb_copy_master_if.sv
// Wishbone classic bus bundle shared by the copy master and its slave.
interface wb_intf #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic                    we_o;
  logic [SELECT_WIDTH-1:0] sel_o;
  logic                    stb_o;
  logic                    cyc_o;
  logic                    ack_i;
  logic                    err_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_copy_master.sv
// Word-by-word memory copy over Wishbone: read one word, write it back, repeat,
// with a per-phase timeout and err_i abort.
module wb_copy_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  xfer_cnt,
  wb_intf.master                wb
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(SELECT_WIDTH);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    stb_q, stb_d;
  logic                    cyc_q, cyc_d;

  // Slave responses only count while a strobe is out; err_i wins over ack_i.
  logic phase_ack, phase_abort;
  assign phase_ack   = stb_q & wb.ack_i & ~wb.err_i;
  assign phase_abort = stb_q & (wb.err_i | (~wb.ack_i & (wait_q == WAIT_LAST)));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = err_q;
    data_d  = data_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = len;
          cnt_d  = '0;
          err_d  = 1'b0;
          wait_d = '0;
          if (len == '0) begin
            state_d = FIN;
          end else begin
            state_d = RD;
            adr_d   = src_addr;
            sel_d   = '1;
            we_d    = 1'b0;
            stb_d   = 1'b1;
            cyc_d   = 1'b1;
          end
        end
      end

      RD, WR: begin
        if (phase_abort) begin
          state_d = FIN;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
        end else if (phase_ack) begin
          wait_d = '0;
          if (state_q == RD) begin
            // Next phase is the write of the word just read.
            state_d = WR;
            data_d  = wb.dat_i;
            adr_d   = dst_q;
            we_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            src_d = src_q + ADDR_STEP;
            dst_d = dst_q + ADDR_STEP;
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = FIN;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              we_d    = 1'b0;
              sel_d   = '0;
            end else begin
              state_d = RD;
              adr_d   = src_q + ADDR_STEP;
              we_d    = 1'b0;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      data_q  <= data_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
    end
  end

  assign wb.adr_o = adr_q;
  assign wb.dat_o = data_q;
  assign wb.sel_o = sel_q;
  assign wb.we_o  = we_q;
  assign wb.stb_o = stb_q;
  assign wb.cyc_o = cyc_q;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign error    = err_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: RAM slave with fault injection, reference copy
// model computed from word addresses, directed and random copies.
module tb_wb_copy_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic        busy, done, error;
  logic [15:0] xfer_cnt;

  wb_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4)) wb ();

  wb_copy_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4), .LEN_WIDTH(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src), .dst_addr(dst), .len(len),
    .busy(busy), .done(done), .error(error), .xfer_cnt(xfer_cnt),
    .wb(wb)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] adr; logic [31:0] dat; } wr_t;

  logic [31:0] mem [0:16383];
  wr_t         wr_log [$];
  logic [15:0] rd_log [$];
  logic        clr;
  logic        ack_q, err_q;
  int          phase;
  int          kill_phase;
  logic        kill_err;
  logic        cyc_seen;
  int          done_cnt;

  assign wb.dat_i = mem[wb.adr_o[15:2]];
  assign wb.ack_i = ack_q;
  assign wb.err_i = err_q;

  // Slave answers each strobe one cycle later; phase kill_phase gets err_i or silence.
  always @(posedge clk) begin
    if (clr) begin
      ack_q <= 1'b0; err_q <= 1'b0; phase <= 0;
      cyc_seen <= 1'b0; done_cnt <= 0;
      wr_log.delete(); rd_log.delete();
    end else begin
      if (wb.cyc_o) cyc_seen <= 1'b1;
      if (done) done_cnt <= done_cnt + 1;
      if (ack_q || err_q) begin
        ack_q <= 1'b0; err_q <= 1'b0; phase <= phase + 1;
        if (ack_q) begin
          if (wb.we_o) wr_log.push_back({wb.adr_o, wb.dat_o});
          else         rd_log.push_back(wb.adr_o);
        end
      end else if (wb.cyc_o && wb.stb_o) begin
        if (phase == kill_phase) begin
          if (kill_err) err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
        end
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_slave(input int kp, input logic ke);
    kill_phase = kp; kill_err = ke;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Pulses start, then counts cycles until done (cycle 1 = first after the sampling edge).
  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                         output int dcyc);
    start = 1'b1; src = s; dst = d; len = n;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = 1;
    while (!done && dcyc < 300) begin
      @(posedge clk); #1;
      dcyc++;
    end
  endtask

  // Reference: word i is read from s+4i and written to d+4i, both modulo 2^16.
  task automatic check_writes(input string tag, input logic [15:0] s, input logic [15:0] d,
                              input int n);
    logic [15:0] sa, da;
    check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      sa = 16'(32'(s) + 4 * i);
      da = 16'(32'(d) + 4 * i);
      check({tag, "_wr_adr"}, 64'(wr_log[i].adr), 64'(da));
      check({tag, "_wr_dat"}, 64'(wr_log[i].dat), 64'(mem[sa[15:2]]));
    end
  endtask

  initial begin
    int          dcyc;
    int          n;
    logic        seen_we;
    logic [15:0] rs, rd;

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    clr = 1'b1; kill_phase = -1; kill_err = 1'b0;
    #1;
    check("rst_cyc",  64'(wb.cyc_o), 64'(0));
    check("rst_stb",  64'(wb.stb_o), 64'(0));
    check("rst_we",   64'(wb.we_o),  64'(0));
    check("rst_adr",  64'(wb.adr_o), 64'(0));
    check("rst_dat",  64'(wb.dat_o), 64'(0));
    check("rst_sel",  64'(wb.sel_o), 64'(0));
    check("rst_busy", 64'(busy),     64'(0));
    check("rst_done", 64'(done),     64'(0));
    check("rst_err",  64'(error),    64'(0));
    check("rst_xfer", 64'(xfer_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal copy of four words.
    clear_slave(-1, 1'b0);
    do_copy(16'h0000, 16'h0100, 16'd4, dcyc);
    check("norm_done_cycle", 64'(dcyc), 64'(17));
    check("norm_busy_in_fin", 64'(busy), 64'(1));
    check("norm_xfer", 64'(xfer_cnt), 64'(4));
    check("norm_err", 64'(error), 64'(0));
    check("norm_cyc_fin", 64'(wb.cyc_o), 64'(0));
    check_writes("norm", 16'h0000, 16'h0100, 4);
    @(posedge clk); #1;
    check("norm_done_one_cycle", 64'(done), 64'(0));
    check("norm_busy_idle", 64'(busy), 64'(0));

    // Zero-length copy.
    clear_slave(-1, 1'b0);
    do_copy(16'h0040, 16'h0800, 16'd0, dcyc);
    check("len0_done_cycle", 64'(dcyc), 64'(1));
    check("len0_xfer", 64'(xfer_cnt), 64'(0));
    @(posedge clk); #1;
    check("len0_cyc_never", 64'(cyc_seen), 64'(0));

    // Address wrap.
    clear_slave(-1, 1'b0);
    do_copy(16'hFFFC, 16'h0200, 16'd2, dcyc);
    check("wrap_done_cycle", 64'(dcyc), 64'(9));
    check("wrap_rd_count", 64'(rd_log.size()), 64'(2));
    if (rd_log.size() == 2) check("wrap_second_rd_adr", 64'(rd_log[1]), 64'(16'h0000));
    check_writes("wrap", 16'hFFFC, 16'h0200, 2);

    // Timeout on the second write: eight waiting cycles, then abort.
    clear_slave(3, 1'b0);
    do_copy(16'h0300, 16'h0900, 16'd3, dcyc);
    check("tmo_done_cycle", 64'(dcyc), 64'(15));
    check("tmo_err", 64'(error), 64'(1));
    check("tmo_xfer", 64'(xfer_cnt), 64'(1));
    check("tmo_cyc_low", 64'(wb.cyc_o), 64'(0));
    check("tmo_stb_low", 64'(wb.stb_o), 64'(0));
    check_writes("tmo", 16'h0300, 16'h0900, 1);
    @(posedge clk); #1;
    check("tmo_err_sticky", 64'(error), 64'(1));

    // err_i on the first read.
    clear_slave(0, 1'b1);
    do_copy(16'h0400, 16'h0A00, 16'd2, dcyc);
    check("berr_done_cycle", 64'(dcyc), 64'(3));
    check("berr_err", 64'(error), 64'(1));
    check("berr_xfer", 64'(xfer_cnt), 64'(0));
    check("berr_cyc_low", 64'(wb.cyc_o), 64'(0));
    @(posedge clk); #1;

    // Start while busy is ignored; the accepted start clears the error flag.
    clear_slave(-1, 1'b0);
    start = 1'b1; src = 16'h0500; dst = 16'h0B00; len = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_err_cleared", 64'(error), 64'(0));
    dcyc = 1;
    while (!done && dcyc < 300) begin
      if (dcyc == 3) begin
        start = 1'b1; src = 16'h0600; dst = 16'h0C00; len = 16'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      dcyc++;
    end
    check("busy_done_cycle", 64'(dcyc), 64'(9));
    check("busy_xfer", 64'(xfer_cnt), 64'(2));
    check_writes("busy", 16'h0500, 16'h0B00, 2);
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_restart", 64'(busy), 64'(0));
    check("busy_one_done", 64'(done_cnt), 64'(1));

    // Reset in the middle of a write phase.
    clear_slave(-1, 1'b0);
    start = 1'b1; src = 16'h0700; dst = 16'h0D00; len = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    seen_we = 1'b0;
    n = 0;
    while (!seen_we && n < 20) begin
      @(posedge clk); #1;
      seen_we = wb.we_o;
      n++;
    end
    check("rstwr_reached_wr", 64'(seen_we), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rstwr_cyc", 64'(wb.cyc_o), 64'(0));
    check("rstwr_stb", 64'(wb.stb_o), 64'(0));
    check("rstwr_busy", 64'(busy), 64'(0));
    check("rstwr_xfer", 64'(xfer_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstwr_no_done", 64'(done_cnt), 64'(0));
    check("rstwr_idle", 64'(busy), 64'(0));

    // Random non-overlapping copies.
    for (int t = 0; t < 4; t++) begin
      rs = 16'(32'h1000 + $urandom_range(0, 1023) * 4);
      rd = 16'(32'h8000 + $urandom_range(0, 4095) * 4);
      n  = int'($urandom_range(1, 6));
      clear_slave(-1, 1'b0);
      do_copy(rs, rd, 16'(n), dcyc);
      check("rand_done_cycle", 64'(dcyc), 64'(4 * n + 1));
      check("rand_xfer", 64'(xfer_cnt), 64'(n));
      check("rand_err", 64'(error), 64'(0));
      check_writes("rand", rs, rd, n);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
